// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/interrupt sequencer (pipe_hazard_ctrl).
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_GUARD    = 2'd2
  } ctrl_state_e;

  // Decoder PCSrc encoding, shared so id_jump/id_error stay in step with the decoder.
  typedef enum logic [2:0] {
    PCSRC_SEQ    = 3'd0,
    PCSRC_BRANCH = 3'd1,
    PCSRC_JUMP   = 3'd2,
    PCSRC_JR     = 3'd3,
    PCSRC_IRQ    = 3'd4,
    PCSRC_ERROR  = 3'd5
  } pcsrc_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pcHold;
    logic ifidHold;
    logic idexHold;
    logic exmemHold;
    logic ifidFlush;
    logic idexFlush;
    logic irqTake;
  } hazard_ctrl_t;

  function automatic logic loadUseHit(
    input logic       exMemRd,
    input logic [4:0] exWrAddr,
    input logic       usesRs,
    input logic [4:0] rs,
    input logic       usesRt,
    input logic [4:0] rt
  );
    return exMemRd && (exWrAddr != REG_ZERO) &&
           ((usesRs && (rs == exWrAddr)) || (usesRt && (rt == exWrAddr)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_irq_guard.sv
// Timer IRQ edge latch, pending flag and post-take guard down-counter for pipe_hazard_ctrl.
module irq_guard #(
  parameter int IRQ_GUARD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic irqIn_i,
  input  logic take_i,
  input  logic busy_i,
  output logic pending_o,
  output logic armed_o
);

  localparam int GW = $clog2(IRQ_GUARD + 1);

  logic          irqIn_q;
  logic          pending_q, pending_d;
  logic [GW-1:0] guard_q, guard_d;

  // A new edge wins over a take in the same cycle so that IRQ is not lost.
  always_comb begin
    pending_d = (irqIn_i & ~irqIn_q) | (pending_q & ~take_i);
  end

  always_comb begin
    guard_d = guard_q;
    if (take_i) begin
      guard_d = GW'(IRQ_GUARD);
    end else if (!busy_i && (guard_q != '0)) begin
      guard_d = guard_q - GW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irqIn_q   <= 1'b0;
      pending_q <= 1'b0;
      guard_q   <= '0;
    end else begin
      irqIn_q   <= irqIn_i;
      pending_q <= pending_d;
      guard_q   <= guard_d;
    end
  end

  assign pending_o = pending_q;
  assign armed_o   = (guard_d != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/interrupt sequencer for the 5-stage pipeline.
// Optional perf counters are built only when HAZ_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int IRQ_GUARD = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             id_error,
  input  logic             ex_memrd,
  input  logic [4:0]       ex_wr_addr,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  input  logic             irq_in,
  input  logic             kernel_mode,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             irq_take,
  output logic             irq_pending,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_irq_cnt
);

  ctrl_state_e  state_q, state_d;
  hazard_ctrl_t ctrl;
  logic         pendingIrq;
  logic         guardArmed;
  logic         loadUse;

  assign loadUse = loadUseHit(ex_memrd, ex_wr_addr, id_uses_rs, id_rs, id_uses_rt, id_rt);

  irq_guard #(
    .IRQ_GUARD(IRQ_GUARD)
  ) u_irq_guard (
    .clk       (clk),
    .reset     (reset),
    .irqIn_i   (irq_in),
    .take_i    (ctrl.irqTake),
    .busy_i    (mem_busy),
    .pending_o (pendingIrq),
    .armed_o   (guardArmed)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Leaving a memory wait resumes the guard window if it has not yet run out.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_busy)          state_d = ST_MEM_WAIT;
        else if (ctrl.irqTake) state_d = ST_GUARD;
      end
      ST_MEM_WAIT: begin
        if (!mem_busy)         state_d = guardArmed ? ST_GUARD : ST_RUN;
      end
      ST_GUARD: begin
        if (mem_busy)          state_d = ST_MEM_WAIT;
        else if (!guardArmed)  state_d = ST_RUN;
      end
      default:                 state_d = ST_RUN;
    endcase
  end

  always_comb begin
    ctrl = '0;
    if (reset) begin
      ctrl.ifidFlush = 1'b1;
      ctrl.idexFlush = 1'b1;
    end else if (mem_busy) begin
      ctrl.pcHold    = 1'b1;
      ctrl.ifidHold  = 1'b1;
      ctrl.idexHold  = 1'b1;
      ctrl.exmemHold = 1'b1;
    end else if (ex_br_taken) begin
      ctrl.ifidFlush = 1'b1;
      ctrl.idexFlush = 1'b1;
    end else if (pendingIrq && !kernel_mode && (state_q == ST_RUN)) begin
      ctrl.irqTake   = 1'b1;
      ctrl.ifidFlush = 1'b1;
    end else if (id_error) begin
      ctrl.ifidFlush = 1'b1;
    end else if (loadUse) begin
      ctrl.pcHold    = 1'b1;
      ctrl.ifidHold  = 1'b1;
      ctrl.idexFlush = 1'b1;
    end else if (id_jump) begin
      ctrl.ifidFlush = 1'b1;
    end
  end

  assign pc_hold     = ctrl.pcHold;
  assign ifid_hold   = ctrl.ifidHold;
  assign idex_hold   = ctrl.idexHold;
  assign exmem_hold  = ctrl.exmemHold;
  assign ifid_flush  = ctrl.ifidFlush;
  assign idex_flush  = ctrl.idexFlush;
  assign irq_take    = ctrl.irqTake;
  assign irq_pending = pendingIrq;

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stallCnt_q, flushCnt_q, irqCnt_q;
  logic             flushEvent;

  // pcHold covers both load-use and memory-wait stalls; reset already forces it low.
  assign flushEvent = ~reset & (ctrl.ifidFlush | ctrl.idexFlush);

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
      irqCnt_q   <= '0;
    end else begin
      if (ctrl.pcHold && (stallCnt_q != '1)) stallCnt_q <= stallCnt_q + CNT_W'(1);
      if (flushEvent && (flushCnt_q != '1))  flushCnt_q <= flushCnt_q + CNT_W'(1);
      if (ctrl.irqTake && (irqCnt_q != '1))  irqCnt_q   <= irqCnt_q + CNT_W'(1);
    end
  end

  assign perf_stall_cnt = stallCnt_q;
  assign perf_flush_cnt = flushCnt_q;
  assign perf_irq_cnt   = irqCnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
  assign perf_irq_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed hazard/IRQ scenarios followed by random cycles,
// all outputs compared every cycle against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int IRQ_GUARD = 4;
  localparam int CNT_W     = 32;

  logic             clk;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_wr_addr;
  logic             id_uses_rs, id_uses_rt, id_jump, id_error;
  logic             ex_memrd, ex_br_taken, mem_busy, irq_in, kernel_mode;
  logic             pc_hold, ifid_hold, idex_hold, exmem_hold;
  logic             ifid_flush, idex_flush, irq_take, irq_pending;
  logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt, perf_irq_cnt;

  pipe_hazard_ctrl #(
    .IRQ_GUARD(IRQ_GUARD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_jump       (id_jump),
    .id_error      (id_error),
    .ex_memrd      (ex_memrd),
    .ex_wr_addr    (ex_wr_addr),
    .ex_br_taken   (ex_br_taken),
    .mem_busy      (mem_busy),
    .irq_in        (irq_in),
    .kernel_mode   (kernel_mode),
    .pc_hold       (pc_hold),
    .ifid_hold     (ifid_hold),
    .idex_hold     (idex_hold),
    .exmem_hold    (exmem_hold),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .irq_take      (irq_take),
    .irq_pending   (irq_pending),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
    .perf_irq_cnt  (perf_irq_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors     = 0;
  int checks      = 0;
  int miscompares = 0;

  // Reference model: pending flag, previous irq level, whether the previous cycle was a
  // memory wait, and the number of non-busy cycles seen since the last take.
  logic        mPending, mIrqPrev, mPrevBusy;
  int          mNbSince;
  int unsigned mStall, mFlush, mIrq;
  logic        nPending, nIrqPrev, nPrevBusy;
  int          nNbSince;
  int unsigned nStall, nFlush, nIrq;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s at vector %0d: observed %0h expected %0h", tag, vectors, observed, expected);
    end
  endtask

  function automatic int unsigned satInc(input int unsigned v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 1 : v;
  endfunction

  task automatic evalAndCheck();
    logic lu, runOk;
    logic ePc, eIfidH, eIdexH, eExmemH, eIfidF, eIdexF, eTake;
    lu = ex_memrd && (ex_wr_addr != 5'd0) &&
         ((id_uses_rs && id_rs == ex_wr_addr) || (id_uses_rt && id_rt == ex_wr_addr));
    runOk = !mPrevBusy && (mNbSince >= IRQ_GUARD);
    {ePc, eIfidH, eIdexH, eExmemH, eIfidF, eIdexF, eTake} = '0;
    if (reset) begin
      eIfidF = 1'b1; eIdexF = 1'b1;
    end else if (mem_busy) begin
      {ePc, eIfidH, eIdexH, eExmemH} = 4'b1111;
    end else if (ex_br_taken) begin
      eIfidF = 1'b1; eIdexF = 1'b1;
    end else if (mPending && !kernel_mode && runOk) begin
      eTake = 1'b1; eIfidF = 1'b1;
    end else if (id_error) begin
      eIfidF = 1'b1;
    end else if (lu) begin
      ePc = 1'b1; eIfidH = 1'b1; eIdexF = 1'b1;
    end else if (id_jump) begin
      eIfidF = 1'b1;
    end

    checkOutput("pc_hold",     {31'd0, pc_hold},     {31'd0, ePc});
    checkOutput("ifid_hold",   {31'd0, ifid_hold},   {31'd0, eIfidH});
    checkOutput("idex_hold",   {31'd0, idex_hold},   {31'd0, eIdexH});
    checkOutput("exmem_hold",  {31'd0, exmem_hold},  {31'd0, eExmemH});
    checkOutput("ifid_flush",  {31'd0, ifid_flush},  {31'd0, eIfidF});
    checkOutput("idex_flush",  {31'd0, idex_flush},  {31'd0, eIdexF});
    checkOutput("irq_take",    {31'd0, irq_take},    {31'd0, eTake});
    checkOutput("irq_pending", {31'd0, irq_pending}, {31'd0, mPending});
`ifdef HAZ_PERF_EN
    checkOutput("perf_stall_cnt", perf_stall_cnt, mStall);
    checkOutput("perf_flush_cnt", perf_flush_cnt, mFlush);
    checkOutput("perf_irq_cnt",   perf_irq_cnt,   mIrq);
`else
    checkOutput("perf_stall_cnt", perf_stall_cnt, 32'd0);
    checkOutput("perf_flush_cnt", perf_flush_cnt, 32'd0);
    checkOutput("perf_irq_cnt",   perf_irq_cnt,   32'd0);
`endif

    if (reset) begin
      nPending = 1'b0; nIrqPrev = 1'b0; nPrevBusy = 1'b0; nNbSince = IRQ_GUARD;
      nStall = 0; nFlush = 0; nIrq = 0;
    end else begin
      nPending  = (irq_in && !mIrqPrev) || (mPending && !eTake);
      nIrqPrev  = irq_in;
      nPrevBusy = mem_busy;
      if (eTake)                           nNbSince = 0;
      else if (!mem_busy && mNbSince < 1000) nNbSince = mNbSince + 1;
      else                                 nNbSince = mNbSince;
      nStall = satInc(mStall, ePc);
      nFlush = satInc(mFlush, eIfidF || eIdexF);
      nIrq   = satInc(mIrq, eTake);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    evalAndCheck();
    @(posedge clk);
    #1;
    mPending  = nPending;
    mIrqPrev  = nIrqPrev;
    mPrevBusy = nPrevBusy;
    mNbSince  = nNbSince;
    mStall    = nStall;
    mFlush    = nFlush;
    mIrq      = nIrq;
    vectors++;
  endtask

  task automatic applyStimulus(
    input logic rst, input logic busy, input logic br, input logic irq, input logic kern,
    input logic err, input logic jmp, input logic memrd, input logic [4:0] wr,
    input logic urs, input logic [4:0] rs, input logic urt, input logic [4:0] rt
  );
    reset = rst; mem_busy = busy; ex_br_taken = br; irq_in = irq; kernel_mode = kern;
    id_error = err; id_jump = jmp; ex_memrd = memrd; ex_wr_addr = wr;
    id_uses_rs = urs; id_rs = rs; id_uses_rt = urt; id_rt = rt;
    stepCycle();
  endtask

  initial begin
    reset = 1'b1; mem_busy = 1'b0; ex_br_taken = 1'b0; irq_in = 1'b0; kernel_mode = 1'b0;
    id_error = 1'b0; id_jump = 1'b0; ex_memrd = 1'b0; ex_wr_addr = 5'd0;
    id_uses_rs = 1'b0; id_rs = 5'd0; id_uses_rt = 1'b0; id_rt = 5'd0;
    mPending = 1'b0; mIrqPrev = 1'b0; mPrevBusy = 1'b0; mNbSince = IRQ_GUARD;
    mStall = 0; mFlush = 0; mIrq = 0;

    repeat (2) applyStimulus(1, 0,0,0,0, 0,0,0,5'd0, 0,5'd0,0,5'd0);
    applyStimulus(0, 0,0,0,0, 0,0,0,5'd0, 0,5'd0,0,5'd0);

    // lw $8 in EX, addu reads $8: one stall cycle, then clear once the load moves on
    applyStimulus(0, 0,0,0,0, 0,0,1,5'd8, 1,5'd8,0,5'd0);
    applyStimulus(0, 0,0,0,0, 0,0,0,5'd8, 1,5'd8,0,5'd0);
    // $zero destination and unused rt never stall; used rt does
    applyStimulus(0, 0,0,0,0, 0,0,1,5'd0, 1,5'd0,1,5'd0);
    applyStimulus(0, 0,0,0,0, 0,0,1,5'd9, 0,5'd1,0,5'd9);
    applyStimulus(0, 0,0,0,0, 0,0,1,5'd9, 0,5'd1,1,5'd9);
    // taken branch overrides load-use and jump
    applyStimulus(0, 0,1,0,0, 0,1,1,5'd8, 1,5'd8,0,5'd0);
    applyStimulus(0, 0,0,0,0, 0,1,0,5'd0, 0,5'd0,0,5'd0);
    applyStimulus(0, 0,0,0,0, 1,1,1,5'd3, 1,5'd3,0,5'd0);

    // IRQ held off in kernel mode, taken once user mode returns, then guarded
    repeat (5) applyStimulus(0, 0,0,1,1, 0,0,0,5'd0, 0,5'd0,0,5'd0);
    applyStimulus(0, 0,0,1,0, 0,0,0,5'd0, 0,5'd0,0,5'd0);
    applyStimulus(0, 0,0,0,0, 0,0,0,5'd0, 0,5'd0,0,5'd0);
    repeat (6) applyStimulus(0, 0,0,1,0, 0,0,0,5'd0, 0,5'd0,0,5'd0);
    applyStimulus(0, 0,0,0,0, 0,0,0,5'd0, 0,5'd0,0,5'd0);

    // memory wait with taken branch held: holds for 3 cycles, flush on the 4th
    repeat (3) applyStimulus(0, 1,1,0,0, 0,0,0,5'd0, 0,5'd0,0,5'd0);
    applyStimulus(0, 0,1,0,0, 0,0,0,5'd0, 0,5'd0,0,5'd0);
    applyStimulus(0, 0,0,0,0, 0,0,0,5'd0, 0,5'd0,0,5'd0);

    // reset during a memory wait with an IRQ pending drops the pending IRQ
    applyStimulus(0, 0,0,1,1, 0,0,0,5'd0, 0,5'd0,0,5'd0);
    repeat (2) applyStimulus(0, 1,0,1,1, 0,0,0,5'd0, 0,5'd0,0,5'd0);
    applyStimulus(1, 1,0,1,1, 0,0,0,5'd0, 0,5'd0,0,5'd0);
    repeat (3) applyStimulus(0, 0,0,1,0, 0,0,0,5'd0, 0,5'd0,0,5'd0);

    for (int i = 0; i < 600; i++) begin
      logic irqNext;
      irqNext = ($urandom_range(0, 4) == 0) ? ~irq_in : irq_in;
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 6) == 0),
                    ($urandom_range(0, 9) == 0),
                    irqNext,
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 6) == 0),
                    ($urandom_range(0, 1) == 0),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) == 0),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) == 0),
                    5'($urandom_range(0, 3)));
    end

    $display("[TB] %0d comparisons made", checks);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
